// File: rtl/poly_pointwise_ctrl.sv
// Pointwise NTT-domain multiply sequencer: streams A/B/zeta pairs through a pipelined
// base-case multiplier and writes (or accumulates) the products into polynomial C.
module base_case_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic [11:0] zeta,
  output logic        valid_o,
  output logic [23:0] c
);
  // Four register stages: products, first reductions, gamma multiply, final sum.
  logic [3:0]  v;
  logic [23:0] s1_p00, s1_p11, s1_p01, s1_p10;
  logic [11:0] s1_g;
  logic [23:0] s2_p00;
  logic [11:0] s2_r11, s2_g;
  logic [24:0] s2_c1s;
  logic [23:0] s3_p00, s3_t;
  logic [11:0] s3_c1;
  logic [11:0] c0_q, c1_q;

  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else     v <= {v[2:0], valid_i};
  end

  always_ff @(posedge clk) begin
    s1_p00 <= 24'(a[11:0]) * 24'(b[11:0]);
    s1_p11 <= 24'(a[23:12]) * 24'(b[23:12]);
    s1_p01 <= 24'(a[11:0]) * 24'(b[23:12]);
    s1_p10 <= 24'(a[23:12]) * 24'(b[11:0]);
    s1_g   <= zeta;
    s2_p00 <= s1_p00;
    s2_r11 <= 12'(s1_p11 % 24'd3329);
    s2_c1s <= 25'(s1_p01) + 25'(s1_p10);
    s2_g   <= s1_g;
    s3_p00 <= s2_p00;
    s3_t   <= 24'(s2_r11) * 24'(s2_g);
    s3_c1  <= 12'(s2_c1s % 25'd3329);
    c0_q   <= 12'((25'(s3_p00) + 25'(s3_t)) % 25'd3329);
    c1_q   <= s3_c1;
  end

  assign valid_o = v[3];
  assign c       = {c1_q, c0_q};
endmodule

module poly_pointwise_ctrl #(
  parameter int N_PAIRS = 128,
  parameter int MUL_LAT = 4,
  parameter int RD_LAT  = 1,
  localparam int AW     = $clog2(N_PAIRS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          acc_i,
  input  logic          hold_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ab_rd_en_o,
  output logic [AW-1:0] ab_rd_addr_o,
  input  logic [23:0]   a_rd_data_i,
  input  logic [23:0]   b_rd_data_i,
  input  logic [11:0]   zeta_rd_data_i,
  output logic          c_rd_en_o,
  output logic [AW-1:0] c_rd_addr_o,
  input  logic [23:0]   c_rd_data_i,
  output logic          c_wr_en_o,
  output logic [AW-1:0] c_wr_addr_o,
  output logic [23:0]   c_wr_data_o
);
  localparam int TAG_D = RD_LAT + MUL_LAT;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] issue_cnt;
  logic          acc_q;
  logic          issue;
  logic [TAG_D-1:0] tag_v;
  logic [AW-1:0] tag_a [TAG_D];
  logic          mul_vo;
  logic [23:0]   mul_c;
  logic [23:0]   sum;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [23:0]   wr_data_q;

  function automatic logic [11:0] mod_add(input logic [11:0] x, input logic [11:0] y);
    logic [12:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 13'd3329) s = s - 13'd3329;
    return s[11:0];
  endfunction

  assign issue = (state == S_RUN) && !hold_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      acc_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          state     <= S_RUN;
          issue_cnt <= '0;
          acc_q     <= acc_i;
        end
        S_RUN: if (!hold_i) begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == AW'(N_PAIRS - 1)) state <= S_DRAIN;
        end
        S_DRAIN: if (wr_en_q && wr_addr_q == AW'(N_PAIRS - 1)) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address tags ride alongside each pair so writes follow issue order across hold gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int j = 0; j < TAG_D; j++) tag_a[j] <= '0;
    end else begin
      tag_v    <= {tag_v[TAG_D-2:0], issue};
      tag_a[0] <= issue_cnt;
      for (int j = 1; j < TAG_D; j++) tag_a[j] <= tag_a[j-1];
    end
  end

  base_case_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .valid_i (tag_v[RD_LAT-1]),
    .a       (a_rd_data_i),
    .b       (b_rd_data_i),
    .zeta    (zeta_rd_data_i),
    .valid_o (mul_vo),
    .c       (mul_c)
  );

  // The old C word is requested so that it returns alongside the product.
  assign c_rd_en_o   = acc_q && tag_v[MUL_LAT-1];
  assign c_rd_addr_o = tag_a[MUL_LAT-1];
  assign sum = {mod_add(c_rd_data_i[23:12], mul_c[23:12]), mod_add(c_rd_data_i[11:0], mul_c[11:0])};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= mul_vo && tag_v[TAG_D-1];
      if (mul_vo) begin
        wr_addr_q <= tag_a[TAG_D-1];
        wr_data_q <= acc_q ? sum : mul_c;
      end
    end
  end

  assign busy_o       = (state == S_RUN) || (state == S_DRAIN);
  assign done_o       = (state == S_DONE);
  assign ab_rd_en_o   = issue;
  assign ab_rd_addr_o = issue_cnt;
  assign c_wr_en_o    = wr_en_q;
  assign c_wr_addr_o  = wr_addr_q;
  assign c_wr_data_o  = wr_data_q;
endmodule

// File: tb/tb_poly_pointwise_ctrl.sv
// Bench for poly_pointwise_ctrl: memory responders, scoreboard of expected C writes, timing checks.
module tb_poly_pointwise_ctrl;
  localparam longint Q = 3329;

  logic clk = 1'b0;
  logic rst, start_i, acc_i, hold_i;
  logic busy_o, done_o, ab_rd_en_o, c_rd_en_o, c_wr_en_o;
  logic [6:0] ab_rd_addr_o, c_rd_addr_o, c_wr_addr_o;
  logic [23:0] a_rd_data_i, b_rd_data_i, c_rd_data_i, c_wr_data_o;
  logic [11:0] zeta_rd_data_i;

  logic [23:0] a_mem [128];
  logic [23:0] b_mem [128];
  logic [11:0] z_mem [128];
  logic [23:0] c_mem [128];
  logic [23:0] c_model [128];
  logic [23:0] saved [128];
  logic [30:0] exp_q [$];
  int done_edges [$];

  int cyc = 0, k = 0;
  int n_cmp = 0, n_bad = 0;
  int wr_cnt, rd_cnt, done_cnt, busy_cnt, first_wr_edge, last_wr_edge, first_rd_edge;

  poly_pointwise_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .acc_i(acc_i), .hold_i(hold_i),
    .busy_o(busy_o), .done_o(done_o),
    .ab_rd_en_o(ab_rd_en_o), .ab_rd_addr_o(ab_rd_addr_o),
    .a_rd_data_i(a_rd_data_i), .b_rd_data_i(b_rd_data_i), .zeta_rd_data_i(zeta_rd_data_i),
    .c_rd_en_o(c_rd_en_o), .c_rd_addr_o(c_rd_addr_o), .c_rd_data_i(c_rd_data_i),
    .c_wr_en_o(c_wr_en_o), .c_wr_addr_o(c_wr_addr_o), .c_wr_data_o(c_wr_data_o)
  );

  // clock / memory responders
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ab_rd_en_o) begin
      a_rd_data_i    <= a_mem[ab_rd_addr_o];
      b_rd_data_i    <= b_mem[ab_rd_addr_o];
      zeta_rd_data_i <= z_mem[ab_rd_addr_o];
    end
    if (c_rd_en_o) c_rd_data_i <= c_mem[c_rd_addr_o];
    if (c_wr_en_o) c_mem[c_wr_addr_o] <= c_wr_data_o;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // reference model: MultiplyNTTs base case with plain integer arithmetic
  function automatic logic [23:0] ref_pair(input int i);
    longint a0, a1, b0, b1, z, c0, c1;
    a0 = a_mem[i][11:0]; a1 = a_mem[i][23:12];
    b0 = b_mem[i][11:0]; b1 = b_mem[i][23:12];
    z  = z_mem[i];
    c0 = (a0 * b0 + a1 * b1 * z) % Q;
    c1 = (a0 * b1 + a1 * b0) % Q;
    return {12'(c1), 12'(c0)};
  endfunction

  function automatic logic [23:0] ref_acc(input logic [23:0] old, input logic [23:0] p);
    longint c0, c1;
    c0 = (longint'(old[11:0]) + longint'(p[11:0])) % Q;
    c1 = (longint'(old[23:12]) + longint'(p[23:12])) % Q;
    return {12'(c1), 12'(c0)};
  endfunction

  // driver tasks
  task automatic fill(input int mode);
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0: begin a_mem[i] = {12'd1, 12'd1}; b_mem[i] = {12'd1, 12'd1}; z_mem[i] = 12'd17; end
        1: begin a_mem[i] = {12'd3328, 12'd0}; b_mem[i] = {12'd3328, 12'd0}; z_mem[i] = 12'd17; end
        default: begin
          a_mem[i] = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
          b_mem[i] = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
          z_mem[i] = 12'($urandom_range(0, 3328));
        end
      endcase
    end
  endtask

  task automatic push_expected(input logic acc);
    logic [23:0] d;
    for (int i = 0; i < 128; i++) begin
      d = acc ? ref_acc(c_model[i], ref_pair(i)) : ref_pair(i);
      exp_q.push_back({7'(i), d});
      c_model[i] = d;
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_wr_edge = -1; last_wr_edge = -1; first_rd_edge = -1;
    done_edges.delete();
  endtask

  task automatic launch(input logic acc);
    push_expected(acc);
    clear_stats();
    @(negedge clk);
    start_i = 1'b1;
    acc_i   = acc;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    start_i = 1'b0;
    acc_i   = ~acc;
  endtask

  // mode 0: no hold, 1: hold 3 cycles after issue 10, 2: random hold
  task automatic wait_done(input int mode);
    int budget = 0;
    while (done_cnt == 0 && budget < 400) begin
      hold_i = (mode == 1 && cyc >= k + 11 && cyc <= k + 13) ||
               (mode == 2 && $urandom_range(0, 3) == 0);
      @(negedge clk);
      budget++;
    end
    hold_i = 1'b0;
    check("done_seen", done_cnt, 1);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("write_count", wr_cnt, 128);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_ab_en"}, ab_rd_en_o, 0);
    check({tag, "_ab_addr"}, ab_rd_addr_o, 0);
    check({tag, "_c_rd_en"}, c_rd_en_o, 0);
    check({tag, "_c_rd_addr"}, c_rd_addr_o, 0);
    check({tag, "_c_wr_en"}, c_wr_en_o, 0);
    check({tag, "_c_wr_addr"}, c_wr_addr_o, 0);
    check({tag, "_c_wr_data"}, c_wr_data_o, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [30:0] e;
    if (c_wr_en_o) begin
      wr_cnt++;
      if (first_wr_edge < 0) first_wr_edge = cyc + 1;
      last_wr_edge = cyc + 1;
      if (exp_q.size() == 0) fail_now("unexpected_write");
      else begin
        e = exp_q.pop_front();
        check("wr_addr", c_wr_addr_o, e[30:24]);
        check("wr_data", c_wr_data_o, e[23:0]);
      end
    end
    if (c_rd_en_o) begin
      check("rd_addr", c_rd_addr_o, rd_cnt % 128);
      if (first_rd_edge < 0) first_rd_edge = cyc + 1;
      rd_cnt++;
    end
    if (done_o) begin
      done_cnt++;
      done_edges.push_back(cyc + 1);
    end
    if (busy_o) busy_cnt++;
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; acc_i = 1'b0; hold_i = 1'b0;
    a_rd_data_i = '0; b_rd_data_i = '0; zeta_rd_data_i = '0; c_rd_data_i = '0;
    for (int i = 0; i < 128; i++) begin
      c_mem[i] = '0; c_model[i] = '0;
    end
    fill(0);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // all ones, zeta 17, overwrite
    launch(1'b0);
    wait_done(0);
    check("s1_first_wr", first_wr_edge, k + 7);
    check("s1_last_wr", last_wr_edge, k + 134);
    check("s1_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 135);
    check("s1_busy_cycles", busy_cnt, 134);
    check("s1_no_c_reads", rd_cnt, 0);
    check("s1_word0", c_mem[0], {12'd2, 12'd18});

    // q-1 boundary values
    fill(1);
    launch(1'b0);
    wait_done(0);
    check("s2_word5", c_mem[5], {12'd0, 12'd17});

    // accumulate onto {3328,3328}
    for (int i = 0; i < 128; i++) begin
      c_mem[i] = {12'd3328, 12'd3328}; c_model[i] = {12'd3328, 12'd3328};
    end
    fill(0);
    launch(1'b1);
    wait_done(0);
    check("s3_first_rd", first_rd_edge, k + 5);
    check("s3_rd_count", rd_cnt, 128);
    check("s3_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 135);
    check("s3_word127", c_mem[127], {12'd1, 12'd17});

    // three hold cycles after issue 10
    fill(2);
    launch(1'b0);
    wait_done(1);
    check("s4_first_wr", first_wr_edge, k + 7);
    check("s4_last_wr", last_wr_edge, k + 137);
    check("s4_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 138);

    // random data with random hold, accumulate then random mode
    fill(2);
    launch(1'b1);
    wait_done(2);
    check("s5_rd_count", rd_cnt, 128);
    fill(2);
    launch(1'($urandom_range(0, 1)));
    wait_done(2);

    // reset in mid-pass: writes up to edge k+50 land, nothing after
    fill(2);
    for (int i = 0; i < 128; i++) saved[i] = c_model[i];
    launch(1'b0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midreset");
    exp_q.delete();
    rst = 1'b0;
    for (int i = 44; i < 128; i++) c_model[i] = saved[i];
    repeat (30) @(negedge clk);
    check("s6_writes_before_reset", wr_cnt, 44);
    check("s6_no_done", done_cnt, 0);
    launch(1'b0);
    wait_done(0);
    check("s6_restart_done_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 135);

    // start held high: back-to-back passes, one per IDLE visit
    begin
      int budget = 0;
      fill(2);
      push_expected(1'b0);
      push_expected(1'b0);
      clear_stats();
      @(negedge clk);
      start_i = 1'b1;
      acc_i   = 1'b0;
      @(posedge clk);
      #1 k = cyc;
      while (done_cnt < 2 && budget < 700) begin
        @(negedge clk);
        if (cyc >= k + 136) start_i = 1'b0;
        budget++;
      end
      start_i = 1'b0;
      repeat (10) @(negedge clk);
      check("s7_done_count", done_cnt, 2);
      check("s7_done0_edge", done_edges.size() > 0 ? done_edges[0] : -1, k + 135);
      check("s7_done1_edge", done_edges.size() > 1 ? done_edges[1] : -1, k + 271);
      check("s7_write_count", wr_cnt, 256);
      check("s7_queue_drained", exp_q.size(), 0);
      check("s7_busy_cycles", busy_cnt, 268);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
